// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared types for the UART receive path.
//   ERR_PARITY/ERR_START/ERR_STOP : bit positions inside a receiver error word
//   uart_err_t                    : 3-bit receiver error status
//   uart_rx_entry_t               : one buffered frame, {err, data}
// -----------------------------------------------------------------------------
package uart_pkg;

  localparam int ERR_PARITY = 0;
  localparam int ERR_START  = 1;
  localparam int ERR_STOP   = 2;

  typedef logic [2:0] uart_err_t;

  typedef struct packed {
    uart_err_t  err;
    logic [7:0] data;
  } uart_rx_entry_t;

endpackage

// File: rtl/uart_sync_edge.sv
// -----------------------------------------------------------------------------
// uart_sync_edge
// Brings an asynchronous level into the clk_i domain with a two-flop
// synchroniser and flags its rising edge.
//   clk_i        : system clock
//   rst_ni       : asynchronous active-low reset
//   async_i      : level from another clock domain
//   firstRise_o  : high while the first stage has risen but the second has not
//   rise_o       : one-cycle pulse per rising edge of the synchronised level
// -----------------------------------------------------------------------------
module uart_sync_edge (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic async_i,
  output logic firstRise_o,
  output logic rise_o
);

  logic meta_q;
  logic sync_q;
  logic hist_q;

  // Two synchroniser stages followed by a history flop; the history flop
  // lets a long high level produce only a single edge pulse.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      hist_q <= 1'b0;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
      hist_q <= sync_q;
    end
  end

  // The first-stage edge arrives one cycle ahead of rise_o, which gives the
  // owner a chance to sample data that is only guaranteed while the level
  // is still high.
  assign firstRise_o = meta_q & ~sync_q;
  assign rise_o      = sync_q & ~hist_q;

endmodule

// File: rtl/uart_rx_fifo.sv
// -----------------------------------------------------------------------------
// uart_rx_fifo
// Receive-side byte buffer behind the UART receiver. Each completed frame
// (rising edge of done_flag) stores {error, data} in a first-word-fall-through
// FIFO that the host drains with a valid/ready handshake.
//   clk, rst_n            : system clock, asynchronous active-low reset
//   done_flag             : frame-complete level, may be asynchronous
//   data_in, error_in     : frame payload and error bits, stable while done_flag
//   rd_ready              : host accepts the head entry
//   clr_overflow          : one-cycle clear of the sticky overflow flag
//   rd_valid/rd_data/rd_error : head entry presentation
//   count, full, empty    : fill status
//   overflow              : sticky, a frame was lost to a full FIFO
//   err_drop              : one-cycle pulse when an errored frame is discarded
// -----------------------------------------------------------------------------
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH    = 16,
  parameter bit DROP_ERR = 1'b0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     done_flag,
  input  logic [7:0]               data_in,
  input  logic [2:0]               error_in,
  input  logic                     rd_ready,
  input  logic                     clr_overflow,
  output logic                     rd_valid,
  output logic [7:0]               rd_data,
  output logic [2:0]               rd_error,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic                     overflow,
  output logic                     err_drop
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DepthCount = CW'(DEPTH);

  logic           firstRise;
  logic           wrEvt;
  logic [7:0]     capData_q;
  uart_err_t      capErr_q;

  logic [PW-1:0]  wrPtr_q,    wrPtr_d;
  logic [PW-1:0]  rdPtr_q,    rdPtr_d;
  logic [CW-1:0]  count_q,    count_d;
  logic           overflow_q, overflow_d;
  logic           errDrop_q,  errDrop_d;

  logic           isFull;
  logic           isEmpty;
  logic           pop;
  logic           dropIt;
  logic           doWrite;
  logic           lost;

  uart_rx_entry_t wrEntry;
  uart_rx_entry_t headEntry;
  uart_rx_entry_t mem_q [DEPTH];

  uart_sync_edge uSyncDone (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .async_i     (done_flag),
    .firstRise_o (firstRise),
    .rise_o      (wrEvt)
  );

  // Capture the payload one cycle before the write event, while done_flag is
  // known to still be high, so the receiver may move on afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      capData_q <= 8'h00;
      capErr_q  <= '0;
    end else if (firstRise) begin
      capData_q <= data_in;
      capErr_q  <= error_in;
    end
  end

  assign isFull  = (count_q == DepthCount);
  assign isEmpty = (count_q == '0);

  // Write/pop decision. A pop frees a slot in the same cycle, so a full FIFO
  // still accepts the frame when the host reads at the same moment.
  always_comb begin
    pop        = 1'b0;
    dropIt     = 1'b0;
    doWrite    = 1'b0;
    lost       = 1'b0;
    wrPtr_d    = wrPtr_q;
    rdPtr_d    = rdPtr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    errDrop_d  = 1'b0;

    pop     = !isEmpty && rd_ready;
    dropIt  = DROP_ERR && (capErr_q != '0);
    doWrite = wrEvt && !dropIt && (!isFull || pop);
    lost    = wrEvt && !dropIt && isFull && !pop;

    if (doWrite) wrPtr_d = wrPtr_q + 1'b1;
    if (pop)     rdPtr_d = rdPtr_q + 1'b1;

    case ({doWrite, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    // Loss wins over a coincident clear so no overflow goes unreported.
    if (lost)              overflow_d = 1'b1;
    else if (clr_overflow) overflow_d = 1'b0;

    errDrop_d = wrEvt && dropIt;
  end

  // Pointer, level and status registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      errDrop_q  <= 1'b0;
    end else begin
      wrPtr_q    <= wrPtr_d;
      rdPtr_q    <= rdPtr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      errDrop_q  <= errDrop_d;
    end
  end

  // Storage is not reset; an entry is only visible once count covers it.
  always_comb begin
    wrEntry      = '0;
    wrEntry.err  = capErr_q;
    wrEntry.data = capData_q;
  end

  always_ff @(posedge clk) begin
    if (doWrite) mem_q[wrPtr_q] <= wrEntry;
  end

  assign headEntry = mem_q[rdPtr_q];

  assign rd_valid = !isEmpty;
  assign rd_data  = headEntry.data;
  assign rd_error = headEntry.err;
  assign count    = count_q;
  assign full     = isFull;
  assign empty    = isEmpty;
  assign overflow = overflow_q;
  assign err_drop = errDrop_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_fifo
// Directed bench for uart_rx_fifo. Two instances share the receiver-side
// inputs: dut0 keeps errored frames, dut1 discards them. Inputs change on the
// falling edge and outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_uart_rx_fifo;

  logic       clk;
  logic       rst_n;
  logic       done_flag;
  logic [7:0] data_in;
  logic [2:0] error_in;
  logic       rdReady0, rdReady1;
  logic       clrOvf0, clrOvf1;

  logic       rdValid0, rdValid1;
  logic [7:0] rdData0, rdData1;
  logic [2:0] rdError0, rdError1;
  logic [4:0] count0, count1;
  logic       full0, full1, empty0, empty1;
  logic       ovf0, ovf1, errDrop0, errDrop1;

  int testsRun;
  int testsFailed;

  uart_rx_fifo #(.DEPTH(16), .DROP_ERR(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .done_flag(done_flag), .data_in(data_in),
    .error_in(error_in), .rd_ready(rdReady0), .clr_overflow(clrOvf0),
    .rd_valid(rdValid0), .rd_data(rdData0), .rd_error(rdError0),
    .count(count0), .full(full0), .empty(empty0), .overflow(ovf0),
    .err_drop(errDrop0)
  );

  uart_rx_fifo #(.DEPTH(16), .DROP_ERR(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .done_flag(done_flag), .data_in(data_in),
    .error_in(error_in), .rd_ready(rdReady1), .clr_overflow(clrOvf1),
    .rd_valid(rdValid1), .rd_data(rdData1), .rd_error(rdError1),
    .count(count1), .full(full1), .empty(empty1), .overflow(ovf1),
    .err_drop(errDrop1)
  );

  // Free-running 100 MHz clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reset both instances and return on a falling edge with rst_n released.
  task automatic doReset();
    @(negedge clk);
    rst_n     = 1'b0;
    done_flag = 1'b0;
    data_in   = 8'h00;
    error_in  = 3'b000;
    rdReady0  = 1'b0;
    rdReady1  = 1'b0;
    clrOvf0   = 1'b0;
    clrOvf1   = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // One receiver frame: done_flag high for 3 cycles, low for 3 cycles, which
  // leaves the write complete and the edge detector re-armed on return.
  task automatic pulseFrame(input logic [7:0] d, input logic [2:0] e);
    data_in   = d;
    error_in  = e;
    done_flag = 1'b1;
    repeat (3) @(negedge clk);
    done_flag = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  // Reset values of every status output.
  task automatic test_reset();
    doReset();
    testsRun++;
    if (rdValid0 !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_rd_valid: got %b expected 0", rdValid0); end
    testsRun++;
    if (empty0 !== 1'b1) begin testsFailed++; $display("[TB] FAIL reset_empty: got %b expected 1", empty0); end
    testsRun++;
    if (count0 !== 5'd0) begin testsFailed++; $display("[TB] FAIL reset_count: got %0d expected 0", count0); end
    testsRun++;
    if ({full0, ovf0, errDrop0} !== 3'b000) begin testsFailed++; $display("[TB] FAIL reset_flags: got %b expected 000", {full0, ovf0, errDrop0}); end
  endtask

  // Single byte: latency of three clocks, then a pop empties the FIFO.
  task automatic test_single_byte();
    doReset();
    data_in   = 8'hA5;
    error_in  = 3'b000;
    done_flag = 1'b1;
    repeat (2) @(negedge clk);
    testsRun++;
    if (rdValid0 !== 1'b0) begin testsFailed++; $display("[TB] FAIL single_early_valid: got %b expected 0", rdValid0); end
    @(negedge clk);
    testsRun++;
    if (rdValid0 !== 1'b1) begin testsFailed++; $display("[TB] FAIL single_valid: got %b expected 1", rdValid0); end
    testsRun++;
    if (rdData0 !== 8'hA5) begin testsFailed++; $display("[TB] FAIL single_data: got %h expected a5", rdData0); end
    testsRun++;
    if (rdError0 !== 3'b000) begin testsFailed++; $display("[TB] FAIL single_error: got %b expected 000", rdError0); end
    testsRun++;
    if (count0 !== 5'd1) begin testsFailed++; $display("[TB] FAIL single_count: got %0d expected 1", count0); end
    done_flag = 1'b0;
    rdReady0  = 1'b1;
    @(negedge clk);
    rdReady0 = 1'b0;
    testsRun++;
    if (empty0 !== 1'b1 || rdValid0 !== 1'b0) begin testsFailed++; $display("[TB] FAIL single_pop_empty: got empty=%b valid=%b expected 1/0", empty0, rdValid0); end
    repeat (3) @(negedge clk);
  endtask

  // 17 frames into a 16-deep FIFO: full after 16, overflow after 17, ordered
  // drain, then a clear of the sticky flag.
  task automatic test_fill_overflow();
    doReset();
    for (int i = 0; i < 17; i++) begin
      pulseFrame(8'(i), 3'b000);
      if (i == 14) begin
        testsRun++;
        if (full0 !== 1'b0) begin testsFailed++; $display("[TB] FAIL fill_not_full_15: got %b expected 0", full0); end
      end
      if (i == 15) begin
        testsRun++;
        if (full0 !== 1'b1 || count0 !== 5'd16) begin testsFailed++; $display("[TB] FAIL fill_full_16: got full=%b count=%0d expected 1/16", full0, count0); end
        testsRun++;
        if (ovf0 !== 1'b0) begin testsFailed++; $display("[TB] FAIL fill_no_ovf_16: got %b expected 0", ovf0); end
      end
    end
    testsRun++;
    if (ovf0 !== 1'b1 || count0 !== 5'd16) begin testsFailed++; $display("[TB] FAIL fill_ovf_17: got ovf=%b count=%0d expected 1/16", ovf0, count0); end
    for (int i = 0; i < 16; i++) begin
      testsRun++;
      if (rdValid0 !== 1'b1 || rdData0 !== 8'(i)) begin testsFailed++; $display("[TB] FAIL fill_drain_%0d: got valid=%b data=%h expected 1/%h", i, rdValid0, rdData0, 8'(i)); end
      rdReady0 = 1'b1;
      @(negedge clk);
      rdReady0 = 1'b0;
    end
    testsRun++;
    if (empty0 !== 1'b1 || ovf0 !== 1'b1) begin testsFailed++; $display("[TB] FAIL fill_drained: got empty=%b ovf=%b expected 1/1", empty0, ovf0); end
    clrOvf0 = 1'b1;
    @(negedge clk);
    clrOvf0 = 1'b0;
    testsRun++;
    if (ovf0 !== 1'b0) begin testsFailed++; $display("[TB] FAIL fill_clr_ovf: got %b expected 0", ovf0); end
  endtask

  // Full FIFO, pop coinciding with the write edge of the 17th frame.
  task automatic test_back_to_back();
    doReset();
    for (int i = 0; i < 16; i++) pulseFrame(8'(i), 3'b000);
    data_in   = 8'h10;
    error_in  = 3'b000;
    done_flag = 1'b1;
    repeat (2) @(negedge clk);
    rdReady0 = 1'b1;
    @(negedge clk);
    rdReady0  = 1'b0;
    done_flag = 1'b0;
    testsRun++;
    if (count0 !== 5'd16 || full0 !== 1'b1) begin testsFailed++; $display("[TB] FAIL b2b_count: got count=%0d full=%b expected 16/1", count0, full0); end
    testsRun++;
    if (ovf0 !== 1'b0) begin testsFailed++; $display("[TB] FAIL b2b_no_ovf: got %b expected 0", ovf0); end
    repeat (3) @(negedge clk);
    for (int i = 1; i < 17; i++) begin
      testsRun++;
      if (rdValid0 !== 1'b1 || rdData0 !== 8'(i)) begin testsFailed++; $display("[TB] FAIL b2b_drain_%0d: got valid=%b data=%h expected 1/%h", i, rdValid0, rdData0, 8'(i)); end
      rdReady0 = 1'b1;
      @(negedge clk);
      rdReady0 = 1'b0;
    end
    testsRun++;
    if (empty0 !== 1'b1) begin testsFailed++; $display("[TB] FAIL b2b_empty: got %b expected 1", empty0); end
  endtask

  // DROP_ERR instance discards an errored frame with a one-cycle pulse.
  task automatic test_drop_err();
    doReset();
    data_in   = 8'h3C;
    error_in  = 3'b100;
    done_flag = 1'b1;
    repeat (2) @(negedge clk);
    testsRun++;
    if (errDrop1 !== 1'b0) begin testsFailed++; $display("[TB] FAIL drop_pulse_early: got %b expected 0", errDrop1); end
    @(negedge clk);
    testsRun++;
    if (errDrop1 !== 1'b1) begin testsFailed++; $display("[TB] FAIL drop_pulse: got %b expected 1", errDrop1); end
    done_flag = 1'b0;
    @(negedge clk);
    testsRun++;
    if (errDrop1 !== 1'b0) begin testsFailed++; $display("[TB] FAIL drop_pulse_len: got %b expected 0", errDrop1); end
    testsRun++;
    if (count1 !== 5'd0) begin testsFailed++; $display("[TB] FAIL drop_count: got %0d expected 0", count1); end
    testsRun++;
    if (count0 !== 5'd1 || rdError0 !== 3'b100 || errDrop0 !== 1'b0) begin testsFailed++; $display("[TB] FAIL drop_keep_inst0: got count=%0d err=%b drop=%b expected 1/100/0", count0, rdError0, errDrop0); end
    repeat (2) @(negedge clk);
    pulseFrame(8'h3D, 3'b000);
    testsRun++;
    if (count1 !== 5'd1 || rdData1 !== 8'h3D || rdError1 !== 3'b000) begin testsFailed++; $display("[TB] FAIL drop_clean_stored: got count=%0d data=%h err=%b expected 1/3d/000", count1, rdData1, rdError1); end
  endtask

  // Error bits pass through when DROP_ERR=0; reset in mid-frame.
  task automatic test_err_reset();
    doReset();
    pulseFrame(8'h55, 3'b001);
    testsRun++;
    if (rdValid0 !== 1'b1 || rdData0 !== 8'h55 || rdError0 !== 3'b001) begin testsFailed++; $display("[TB] FAIL pass_err: got valid=%b data=%h err=%b expected 1/55/001", rdValid0, rdData0, rdError0); end
    data_in   = 8'h66;
    error_in  = 3'b000;
    done_flag = 1'b1;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    testsRun++;
    if (rdValid0 !== 1'b0 || empty0 !== 1'b1 || count0 !== 5'd0) begin testsFailed++; $display("[TB] FAIL midreset_outputs: got valid=%b empty=%b count=%0d expected 0/1/0", rdValid0, empty0, count0); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    testsRun++;
    if (rdValid0 !== 1'b0) begin testsFailed++; $display("[TB] FAIL midreset_early: got %b expected 0", rdValid0); end
    @(negedge clk);
    testsRun++;
    if (rdValid0 !== 1'b1 || rdData0 !== 8'h66 || count0 !== 5'd1) begin testsFailed++; $display("[TB] FAIL midreset_event: got valid=%b data=%h count=%0d expected 1/66/1", rdValid0, rdData0, count0); end
    done_flag = 1'b0;
    repeat (3) @(negedge clk);
    testsRun++;
    if (count0 !== 5'd1) begin testsFailed++; $display("[TB] FAIL midreset_single: got %0d expected 1", count0); end
  endtask

  initial begin
    testsRun    = 0;
    testsFailed = 0;
    rst_n       = 1'b0;
    done_flag   = 1'b0;
    data_in     = 8'h00;
    error_in    = 3'b000;
    rdReady0    = 1'b0;
    rdReady1    = 1'b0;
    clrOvf0     = 1'b0;
    clrOvf1     = 1'b0;

    test_reset();
    test_single_byte();
    test_fill_overflow();
    test_back_to_back();
    test_drop_err();
    test_err_reset();

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Receive-side byte buffer that sits directly downstream of the UART receiver and consumes its `done_flag`, `data_out` and `error_flag` outputs. It synchronises the receiver's completion flag into the system clock domain and detects its rising edge. On each completed frame it writes the 8-bit payload and its 3-bit error status into a first-word-fall-through FIFO. The host side drains that FIFO through a valid/ready handshake; the block also provides fill-level, full/empty and sticky overflow status.

## Interface
Parameters:
- `DEPTH`, 16 — FIFO entries; must be a power of two, ≥ 2.
- `DROP_ERR`, 0 — 1: frames with any error bit set are discarded, not stored.

Ports:
- `clk`  in  1  system clock; one clock, all logic on its rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `done_flag`  in  1  frame-complete level from the receiver; may be asynchronous to `clk`.
- `data_in`  in  8  received byte; stable while `done_flag` is high.
- `error_in`  in  3  receiver error bits; stable while `done_flag` is high.
- `rd_ready`  in  1  host accepts the head entry.
- `clr_overflow`  in  1  single-cycle clear of `overflow`.
- `rd_valid`  out  1  FIFO not empty; head entry is presented.
- `rd_data`  out  8  head byte.
- `rd_error`  out  3  head error bits.
- `count`  out  $clog2(DEPTH)+1  stored entries, 0..DEPTH.
- `full`  out  1  `count == DEPTH`.
- `empty`  out  1  `count == 0`.
- `overflow`  out  1  sticky; set when a frame is lost because the FIFO is full.
- `err_drop`  out  1  one-cycle pulse when a frame is discarded under `DROP_ERR=1`.

## Operation
- **Done-flag synchroniser:** `done_flag` passes through a 2-flop synchroniser and a third history flop. `wr_evt` = sync_q & ~hist_q, i.e. one cycle per rising edge. A level held high for many cycles produces exactly one event.
- **Capture:** `data_in` and `error_in` are registered into a capture stage on the first synchroniser stage's rising edge. This guarantees they are sampled while `done_flag` is still high, and the captured values are used at `wr_evt`.
- **Write decision at `wr_evt`:**
  - If `DROP_ERR=1` and captured error ≠ 0: no write, pulse `err_drop`.
  - Else if not full, or a pop occurs in the same cycle: write at `wr_ptr`, then `wr_ptr++`.
  - Else: frame lost, set `overflow`.
- **Pop:** `rd_valid & rd_ready` advances `rd_ptr`. `rd_ready` with `rd_valid=0` has no effect.
- **Pointers:** `$clog2(DEPTH)` bits, natural wrap at DEPTH; no modulo logic.
- **`count` update:** +1 on write only, −1 on pop only, unchanged on both.
- **`overflow`:** set on lost frame and cleared by `clr_overflow`. If both occur in the same cycle, set wins.
- **Storage:** 11 bits per entry, {error[2:0], data[7:0]}. Error bit order: [0] parity, [1] start, [2] stop.

## Timing
- **Reset:** all outputs 0 except `empty=1`. Pointers, `count`, synchroniser and capture flops are cleared. Storage contents are don't-care.
- **Reset during a frame:** the event is lost. If `done_flag` is still high at deassertion, the history flop's reset value of 0 yields one event 2 cycles after release; this is accepted behaviour.
- **Write latency:** `done_flag` rising (sampled at clk edge N) → `wr_evt` in cycle N+2 → `rd_valid` high and `rd_data` valid in cycle N+3.
- **Read:** FWFT, zero-latency head; the next entry appears in the cycle after a pop. `rd_data`/`rd_error` are don't-care while `rd_valid=0`.
- **Simultaneous write and pop:**
  - When empty: the write proceeds; the pop cannot occur because `rd_valid=0`.
  - When full: both are accepted and `full` stays 1.
- **Status timing:** `full`, `empty` and `count` are registered-consistent, updating in the cycle after the causing event.

## Structure
- **Package `uart_pkg`:** error-bit index constants `ERR_PARITY=0`, `ERR_START=1`, `ERR_STOP=2`; typedef `uart_err_t` (logic [2:0]); typedef `uart_rx_entry_t` (packed struct {err, data}).
- **Sub-module `uart_sync_edge`:** 2-flop synchroniser plus rising-edge pulse, with async active-low reset. It is reused elsewhere for other receiver flags.
- **Storage:** register array inside `uart_rx_fifo`; no RAM macro.

## Test plan
- **Single byte:** reset, pulse `done_flag` with 0xA5, error 0. Required: `rd_valid` 3 clks later, `rd_data=0xA5`, `rd_error=0`, `count=1`. With `rd_ready=1`: `empty=1` next cycle.
- **Fill and overflow (DEPTH=16):** 17 frames 0x00..0x10, no reads. Required: `full=1` after 16, `overflow=1` after the 17th. Draining gives 0x00..0x0F in order. `clr_overflow` then clears the flag.
- **Write and pop together when full:** `rd_ready` held high while the 17th frame arrives. Required: no overflow, `count` stays 16, 0x10 is eventually read last.
- **`DROP_ERR=1`:** frame 0x3C with error 3'b100. Required: `err_drop` pulses one cycle, `count` stays 0. A frame 0x3D with error 0 is stored.
- **`DROP_ERR=0` error pass-through, then mid-frame reset:** frame 0x55 with error 3'b001 is stored with `rd_error=3'b001`. Reset asserted while `done_flag` is high: all outputs go to reset values immediately, and one event is stored 2 cycles after release.
